// File: rtl/nr2_latch_bank.sv
// -----------------------------------------------------------------------------
// nr2_latch_bank
//   Clocked WIDTH-bit bank of NOR2-input storage bits behind a differential
//   enable pair, with tri-stated true/complement outputs, a save/restore shadow
//   register and a sticky enable-pair fault monitor.
//
// Ports
//   CK        clock, all state updates on the rising edge
//   RN        synchronous active-low reset, sampled on CK rise
//   A0, A1    data input legs (WIDTH bits each)
//   EN, ENB   enable pair: 10 = LOAD, 01 = HOLD, 00/11 = INVALID
//   SAVE      copy store -> shadow (old store value, in parallel with update)
//   RESTORE   copy shadow -> store (priority over LOAD)
//   Q, QB     stored data and its complement; Z unless pair valid and ACTIVE
//   FAULT     sticky enable-pair fault flag, cleared only by reset
//   VALID     store holds loaded (not reset) data
//   fsm_state current controller state (0 = ACTIVE, 1 = FAULTED)
//   VDD, VSS  supply rails; the levels written for a stored 1 / stored 0
//
// Interface timing: there is no valid/ready handshake. Every CK rise samples
// the inputs; the effect of LOAD/SAVE/RESTORE is visible on Q/QB right after
// that edge. Output enable follows EN/ENB combinationally.
// -----------------------------------------------------------------------------
module nr2_latch_bank #(
  parameter int WIDTH        = 8,
  parameter int FAULT_CYCLES = 4,
  parameter bit INV_POL      = 1'b1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             EN,
  input  logic             ENB,
  input  logic             SAVE,
  input  logic             RESTORE,
  output wire  [WIDTH-1:0] Q,
  output wire  [WIDTH-1:0] QB,
  output logic             FAULT,
  output logic             VALID,
  output logic             fsm_state,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int CW = $clog2(FAULT_CYCLES + 1);

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_FAULTED = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] store;
  logic [WIDTH-1:0] shadow;
  logic             shadow_valid;
  logic [CW-1:0]    cnt;

  logic             pair_valid;
  logic             load;
  logic             out_en;
  logic [WIDTH-1:0] load_data;

  assign pair_valid = EN ^ ENB;
  assign load       = EN & ~ENB;
  assign out_en     = pair_valid && (state == ST_ACTIVE);
  assign fsm_state  = state;

  // With INV_POL=1 a bit stores the NOR of its legs: any leg high selects VSS.
  // INV_POL=0 flips the selection, giving OR behaviour.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_data[i] = ((A0[i] | A1[i]) ^ INV_POL) ? VDD : VSS;
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state        <= ST_ACTIVE;
      store        <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      VALID        <= 1'b0;
      cnt          <= '0;
      FAULT        <= 1'b0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (pair_valid) begin
            if (RESTORE) begin
              store <= shadow;
              VALID <= shadow_valid;
            end else if (load) begin
              store <= load_data;
              VALID <= 1'b1;
            end
            // Samples the pre-edge store, so SAVE+RESTORE swaps the two.
            if (SAVE) begin
              shadow       <= store;
              shadow_valid <= VALID;
            end
            cnt <= '0;
          end else begin
            if (cnt != CW'(FAULT_CYCLES)) cnt <= cnt + CW'(1);
            if (cnt == CW'(FAULT_CYCLES - 1)) begin
              state <= ST_FAULTED;
              FAULT <= 1'b1;
            end
          end
        end
        ST_FAULTED: begin
          // Frozen until reset.
          FAULT <= 1'b1;
        end
        default: begin
          state <= ST_ACTIVE;
        end
      endcase
    end
  end

  assign Q  = out_en ? store  : {WIDTH{1'bz}};
  assign QB = out_en ? ~store : {WIDTH{1'bz}};

endmodule
